// File: rtl/bram_arbiter_pkg.sv
// ============================================================
// bram_arbiter_pkg : shared constants and FSM encoding for the BRAM front end
// Revision: 1.0
// ============================================================
`default_nettype none

package bram_arbiter_pkg;
  localparam int BRAM_ADDR_W  = 13;
  localparam int BRAM_DATA_W  = 32;
  localparam int BRAM_LATENCY = 10;

  localparam logic SEL_DMA = 1'b0;
  localparam logic SEL_CPU = 1'b1;

  typedef enum logic [0:0] {
    S_DMA_PRI    = 1'b0,
    S_CACHE_TURN = 1'b1
  } arb_state_t;
endpackage

`default_nettype wire

// File: rtl/bram_credit_cnt.sv
// ============================================================
// bram_credit_cnt : saturating up/down read-credit counter with limit and underflow
// Revision: 1.0
// ============================================================
`default_nettype none

module bram_credit_cnt #(
  parameter int LIMIT = 10,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_avail,
  output logic o_underflow
);
  logic [CNT_W-1:0] r_cnt;
  logic             w_zero;

  assign w_zero      = (r_cnt == '0);
  assign o_avail     = (r_cnt < CNT_W'(LIMIT));
  // A return with nothing outstanding is a protocol error; the count stays at 0.
  assign o_underflow = i_dec & w_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && o_avail) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && !w_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/bram_arbiter.sv
// ============================================================
// bram_arbiter : weighted cache/DMA arbiter with read credits in front of the BRAM controller
// Revision: 1.0
// ============================================================
`default_nettype none

module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int ADDR_W          = BRAM_ADDR_W,
  parameter int DATA_W          = BRAM_DATA_W,
  parameter int DMA_WEIGHT      = 4,
  parameter int MAX_OUTSTANDING = BRAM_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_req_valid,
  output logic              cache_req_ready,
  input  logic [ADDR_W-1:0] cache_req_addr,
  input  logic              dma_req_valid,
  output logic              dma_req_ready,
  input  logic              dma_req_we,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic [DATA_W-1:0] dma_req_wdata,
  output logic              WR,
  output logic              In_valid,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] Di,
  output logic              reader_sel,
  input  logic              Out_valid,
  input  logic              dma_ack,
  output logic              credit_err
);
  arb_state_t        r_state, w_state_nxt;
  logic [3:0]        r_dma_run, w_run_nxt;
  logic [3:0]        r_holdoff;
  logic              r_wr, r_in_valid, r_sel, r_credit_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_di;

  logic w_holdoff, w_cache_avail, w_dma_avail, w_cache_uf, w_dma_uf;
  logic w_cache_ok, w_dma_ok, w_grant_cache, w_grant_dma;

  assign w_holdoff  = (r_holdoff != 4'd0);
  assign w_cache_ok = cache_req_valid & w_cache_avail;
  assign w_dma_ok   = dma_req_valid & (dma_req_we | w_dma_avail);

  bram_credit_cnt #(.LIMIT(MAX_OUTSTANDING), .CNT_W(4)) u_cache_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_inc       (w_grant_cache),
    .i_dec       (Out_valid & ~w_holdoff),
    .o_avail     (w_cache_avail),
    .o_underflow (w_cache_uf)
  );

  bram_credit_cnt #(.LIMIT(MAX_OUTSTANDING), .CNT_W(4)) u_dma_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_inc       (w_grant_dma & ~dma_req_we),
    .i_dec       (dma_ack & ~w_holdoff),
    .o_avail     (w_dma_avail),
    .o_underflow (w_dma_uf)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_run_nxt     = r_dma_run;
    w_grant_cache = 1'b0;
    w_grant_dma   = 1'b0;
    case (r_state)
      S_DMA_PRI: begin
        if (w_dma_ok) begin
          w_grant_dma = 1'b1;
        end else if (w_cache_ok) begin
          w_grant_cache = 1'b1;
        end
        // Only DMA grants that actually made the cache wait count toward the weight.
        if (!w_cache_ok || w_grant_cache) begin
          w_run_nxt = 4'd0;
        end else if (w_grant_dma) begin
          w_run_nxt = r_dma_run + 4'd1;
          if (w_run_nxt == 4'(DMA_WEIGHT)) begin
            w_state_nxt = S_CACHE_TURN;
          end
        end
      end
      S_CACHE_TURN: begin
        if (w_cache_ok) begin
          w_grant_cache = 1'b1;
          w_run_nxt     = 4'd0;
          w_state_nxt   = S_DMA_PRI;
        end else if (w_dma_ok) begin
          w_grant_dma = 1'b1;
        end
      end
      default: w_state_nxt = S_DMA_PRI;
    endcase
  end

  assign cache_req_ready = w_grant_cache;
  assign dma_req_ready   = w_grant_dma;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_DMA_PRI;
      r_dma_run <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_dma_run <= w_run_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_valid <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_di       <= '0;
      r_sel      <= SEL_DMA;
    end else begin
      r_in_valid <= w_grant_cache | w_grant_dma;
      if (w_grant_cache) begin
        r_wr   <= 1'b0;
        r_addr <= cache_req_addr;
        r_di   <= '0;
        r_sel  <= SEL_CPU;
      end else if (w_grant_dma) begin
        r_wr   <= dma_req_we;
        r_addr <= dma_req_addr;
        r_di   <= dma_req_wdata;
        r_sel  <= SEL_DMA;
      end
    end
  end

  // Returns from reads issued before reset drain during the holdoff window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_holdoff    <= 4'(BRAM_LATENCY);
      r_credit_err <= 1'b0;
    end else begin
      if (w_holdoff) begin
        r_holdoff <= r_holdoff - 4'd1;
      end
      if (w_cache_uf || w_dma_uf) begin
        r_credit_err <= 1'b1;
      end
    end
  end

  assign WR         = r_wr;
  assign In_valid   = r_in_valid;
  assign Addr       = r_addr;
  assign Di         = r_di;
  assign reader_sel = r_sel;
  assign credit_err = r_credit_err;
endmodule

`default_nettype wire

// File: tb/tb_bram_arbiter.sv
// ============================================================
// tb_bram_arbiter : directed self-checking bench for bram_arbiter
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_bram_arbiter;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cache_req_valid = 1'b0;
  logic              cache_req_ready;
  logic [ADDR_W-1:0] cache_req_addr = '0;
  logic              dma_req_valid = 1'b0;
  logic              dma_req_ready;
  logic              dma_req_we = 1'b0;
  logic [ADDR_W-1:0] dma_req_addr = '0;
  logic [DATA_W-1:0] dma_req_wdata = '0;
  logic              WR, In_valid, reader_sel, credit_err;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] Di;
  logic              Out_valid = 1'b0;
  logic              dma_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DMA_WEIGHT(4), .MAX_OUTSTANDING(10)) dut (
    .clk(clk), .rst(rst),
    .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready), .cache_req_addr(cache_req_addr),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_we(dma_req_we),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
    .WR(WR), .In_valid(In_valid), .Addr(Addr), .Di(Di), .reader_sel(reader_sel),
    .Out_valid(Out_valid), .dma_ack(dma_ack), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (In_valid !== 1'b0) begin failures++; $display("FAIL reset_in_valid got=%b exp=0", In_valid); end
    checks++; if (WR !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", WR); end
    checks++; if (Addr !== 13'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", Addr); end
    checks++; if (Di !== 32'h0) begin failures++; $display("FAIL reset_di got=%h exp=0", Di); end
    checks++; if (reader_sel !== 1'b0) begin failures++; $display("FAIL reset_sel got=%b exp=0", reader_sel); end
    checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL reset_credit_err got=%b exp=0", credit_err); end
    rst = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_single_cache();
    cache_req_valid = 1'b1;
    cache_req_addr  = 13'h0010;
    #1;
    checks++; if (cache_req_ready !== 1'b1) begin failures++; $display("FAIL single_cache_ready got=%b exp=1", cache_req_ready); end
    checks++; if (dma_req_ready !== 1'b0) begin failures++; $display("FAIL single_dma_ready got=%b exp=0", dma_req_ready); end
    tick();
    cache_req_valid = 1'b0;
    checks++; if (In_valid !== 1'b1) begin failures++; $display("FAIL single_in_valid got=%b exp=1", In_valid); end
    checks++; if (WR !== 1'b0) begin failures++; $display("FAIL single_wr got=%b exp=0", WR); end
    checks++; if (Addr !== 13'h0010) begin failures++; $display("FAIL single_addr got=%h exp=0010", Addr); end
    checks++; if (reader_sel !== 1'b1) begin failures++; $display("FAIL single_sel got=%b exp=1", reader_sel); end
    checks++; if (Di !== 32'h0) begin failures++; $display("FAIL single_di got=%h exp=0", Di); end
    tick();
    checks++; if (In_valid !== 1'b0) begin failures++; $display("FAIL single_idle_in_valid got=%b exp=0", In_valid); end
    checks++; if (Addr !== 13'h0010) begin failures++; $display("FAIL single_addr_hold got=%h exp=0010", Addr); end
    Out_valid = 1'b1;
    tick();
    Out_valid = 1'b0;
    checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL single_credit_err got=%b exp=0", credit_err); end
  endtask

  task automatic test_weighted();
    logic exp_c [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    dma_req_valid   = 1'b1;
    dma_req_we      = 1'b1;
    dma_req_addr    = 13'h0200;
    dma_req_wdata   = 32'h1111_0000;
    cache_req_valid = 1'b1;
    cache_req_addr  = 13'h0040;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (cache_req_ready !== exp_c[i]) begin failures++; $display("FAIL weighted_cache_ready[%0d] got=%b exp=%b", i, cache_req_ready, exp_c[i]); end
      checks++; if (dma_req_ready !== !exp_c[i]) begin failures++; $display("FAIL weighted_dma_ready[%0d] got=%b exp=%b", i, dma_req_ready, !exp_c[i]); end
      tick();
      checks++; if (reader_sel !== exp_c[i]) begin failures++; $display("FAIL weighted_sel[%0d] got=%b exp=%b", i, reader_sel, exp_c[i]); end
      checks++; if (WR !== !exp_c[i]) begin failures++; $display("FAIL weighted_wr[%0d] got=%b exp=%b", i, WR, !exp_c[i]); end
    end
    dma_req_valid   = 1'b0;
    cache_req_valid = 1'b0;
    Out_valid       = 1'b1;
    tick();
    tick();
    Out_valid = 1'b0;
    checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL weighted_credit_err got=%b exp=0", credit_err); end
  endtask

  task automatic test_cache_limit();
    cache_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cache_req_addr = 13'h0100 + 13'(i);
      #1;
      checks++; if (cache_req_ready !== 1'b1) begin failures++; $display("FAIL limit_ready[%0d] got=%b exp=1", i, cache_req_ready); end
      tick();
    end
    cache_req_addr = 13'h010A;
    #1;
    checks++; if (cache_req_ready !== 1'b0) begin failures++; $display("FAIL limit_11th_ready got=%b exp=0", cache_req_ready); end
    tick();
    checks++; if (In_valid !== 1'b0) begin failures++; $display("FAIL limit_blocked_in_valid got=%b exp=0", In_valid); end
    Out_valid = 1'b1;
    #1;
    checks++; if (cache_req_ready !== 1'b0) begin failures++; $display("FAIL limit_ready_at_return got=%b exp=0", cache_req_ready); end
    tick();
    Out_valid = 1'b0;
    #1;
    checks++; if (cache_req_ready !== 1'b1) begin failures++; $display("FAIL limit_ready_reassert got=%b exp=1", cache_req_ready); end
    tick();
    cache_req_valid = 1'b0;
    checks++; if (In_valid !== 1'b1) begin failures++; $display("FAIL limit_11th_in_valid got=%b exp=1", In_valid); end
    checks++; if (Addr !== 13'h010A) begin failures++; $display("FAIL limit_11th_addr got=%h exp=010a", Addr); end
    Out_valid = 1'b1;
    repeat (10) tick();
    Out_valid = 1'b0;
    checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL limit_drain_credit_err got=%b exp=0", credit_err); end
  endtask

  task automatic test_dma_write_bypass();
    dma_req_valid = 1'b1;
    dma_req_we    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dma_req_addr = 13'h0300 + 13'(i);
      #1;
      checks++; if (dma_req_ready !== 1'b1) begin failures++; $display("FAIL dma_read_ready[%0d] got=%b exp=1", i, dma_req_ready); end
      tick();
    end
    #1;
    checks++; if (dma_req_ready !== 1'b0) begin failures++; $display("FAIL dma_read_blocked got=%b exp=0", dma_req_ready); end
    tick();
    dma_req_we    = 1'b1;
    dma_req_addr  = 13'h0123;
    dma_req_wdata = 32'hCAFE_F00D;
    #1;
    checks++; if (dma_req_ready !== 1'b1) begin failures++; $display("FAIL dma_write_ready got=%b exp=1", dma_req_ready); end
    tick();
    checks++; if (WR !== 1'b1) begin failures++; $display("FAIL dma_write_wr got=%b exp=1", WR); end
    checks++; if (Di !== 32'hCAFE_F00D) begin failures++; $display("FAIL dma_write_di got=%h exp=cafef00d", Di); end
    checks++; if (reader_sel !== 1'b0) begin failures++; $display("FAIL dma_write_sel got=%b exp=0", reader_sel); end
    checks++; if (Addr !== 13'h0123) begin failures++; $display("FAIL dma_write_addr got=%h exp=0123", Addr); end
    dma_req_we = 1'b0;
    #1;
    checks++; if (dma_req_ready !== 1'b0) begin failures++; $display("FAIL dma_cnt_unchanged got=%b exp=0", dma_req_ready); end
    dma_req_valid = 1'b0;
    dma_ack       = 1'b1;
    repeat (10) tick();
    dma_ack       = 1'b0;
    dma_req_valid = 1'b1;
    #1;
    checks++; if (dma_req_ready !== 1'b1) begin failures++; $display("FAIL dma_read_after_drain got=%b exp=1", dma_req_ready); end
    dma_req_valid = 1'b0;
    tick();
    checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL dma_drain_credit_err got=%b exp=0", credit_err); end
  endtask

  task automatic test_credit_err();
    Out_valid = 1'b1;
    tick();
    Out_valid = 1'b0;
    checks++; if (credit_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", credit_err); end
    repeat (3) tick();
    checks++; if (credit_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", credit_err); end
    cache_req_valid = 1'b1;
    #1;
    checks++; if (cache_req_ready !== 1'b1) begin failures++; $display("FAIL err_cnt_zero_ready got=%b exp=1", cache_req_ready); end
    cache_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    cache_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cache_req_addr = 13'h0050 + 13'(i);
      tick();
    end
    cache_req_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (In_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_in_valid got=%b exp=0", In_valid); end
    checks++; if (Addr !== 13'h0) begin failures++; $display("FAIL mid_rst_addr got=%h exp=0", Addr); end
    checks++; if (reader_sel !== 1'b0) begin failures++; $display("FAIL mid_rst_sel got=%b exp=0", reader_sel); end
    checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL mid_rst_credit_err got=%b exp=0", credit_err); end
    rst       = 1'b0;
    Out_valid = 1'b1;
    repeat (10) tick();
    Out_valid = 1'b0;
    checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL holdoff_credit_err got=%b exp=0", credit_err); end
    Out_valid = 1'b1;
    tick();
    Out_valid = 1'b0;
    checks++; if (credit_err !== 1'b1) begin failures++; $display("FAIL post_holdoff_err got=%b exp=1", credit_err); end
  endtask

  initial begin
    test_reset();
    test_single_cache();
    test_weighted();
    test_cache_limit();
    test_dma_write_bypass();
    test_credit_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
